// File: rtl/xt_unit_pkg.sv
// Shared definitions for the xt_unit target-side switch port.
// Provides the VC index width and the field layout of the request packet so the
// unit and anything that builds or decodes packets agree on one layout.
// Request packet layout, MSB first: {DST_ID, SRC_ID, WR, VC, ADR, SB, STB, DAT}.
package xt_unit_pkg;

   // Fields listed from the LSB upwards, so the enum order defines the offsets.
   typedef enum logic [2:0] {
      FldDat = 3'd0,
      FldStb = 3'd1,
      FldSb  = 3'd2,
      FldAdr = 3'd3,
      FldVc  = 3'd4,
      FldWr  = 3'd5,
      FldSrc = 3'd6,
      FldDst = 3'd7
   } fld_e;

   // A single VC still needs a one-bit VC field.
   function automatic int unsigned calc_vcw(input int unsigned vcn);
      return (vcn <= 2) ? 1 : $clog2(vcn);
   endfunction

   function automatic int unsigned fld_w(input fld_e f, input int unsigned m, n, vcw, a, sb, d);
      int unsigned w;
      w = 0;
      case (f)
         FldDat:  w = d;
         FldStb:  w = d / 8;
         FldSb:   w = sb;
         FldAdr:  w = a;
         FldVc:   w = vcw;
         FldWr:   w = 1;
         FldSrc:  w = n;
         FldDst:  w = m;
         default: w = 0;
      endcase
      return w;
   endfunction

   function automatic int unsigned fld_off(input fld_e f, input int unsigned m, n, vcw, a, sb, d);
      int unsigned off;
      off = 0;
      for (int i = 0; i < int'(f); i++) begin
         off += fld_w(fld_e'(i), m, n, vcw, a, sb, d);
      end
      return off;
   endfunction

   // Request packet width.
   function automatic int unsigned calc_tp(input int unsigned m, n, vcw, a, sb, d);
      return fld_off(FldDst, m, n, vcw, a, sb, d) + m;
   endfunction

   // Response packet width: {DST_ID, SRC_ID, VC, ERR, DAT}.
   function automatic int unsigned calc_rp(input int unsigned n, m, vcw, d);
      return n + m + vcw + 1 + d;
   endfunction

endpackage

// File: rtl/xt_sfifo.sv
// Synchronous FIFO with first-word fall-through read and registered flags.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, wdata   write strobe and data (ignored while full)
//   pop           read strobe (ignored while empty)
//   rdata         head entry, valid while !empty
//   full, empty   registered occupancy flags
// Depth must be a power of two >= 2; pointers carry one extra wrap bit.
module xt_sfifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] mem_q [Depth];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   assign do_push = push && !full_q;
   assign do_pop  = pop && !empty_q;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         empty_q <= (wptr_d == rptr_d);
         full_q  <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
      end
   end

   // Storage needs no reset: contents are only visible through the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

   assign rdata = mem_q[rptr_q[AW-1:0]];
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/xt_unit_mvc.sv
// Multi-VC target unit: accepts switch packets, queues them per VC, issues them
// round-robin to a target, and routes in-order target responses back to their
// source using a per-VC tag FIFO of source IDs.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   t_vld/t_pld/t_gnt          incoming request packet
//   req_* / req_gnt            request to the target (held until granted)
//   rsp_* / rsp_gnt            response from the target
//   r_vld/r_pld/r_gnt          outgoing response packet
//   id_err, orphan_err         sticky misroute / orphan-response flags
//   drop_cnt                   saturating count of dropped packets
module xt_unit_mvc import xt_unit_pkg::*; #(
   parameter  int unsigned N   = 2,
   parameter  int unsigned M   = 3,
   parameter  int unsigned A   = 19,
   parameter  int unsigned D   = 32,
   parameter  int unsigned SB  = 4,
   parameter  int unsigned VCN = 2,
   parameter  int unsigned BUF = 4,
   parameter  int unsigned OST = 4,
   parameter  int unsigned ID  = 0,
   localparam int unsigned VCW = calc_vcw(VCN),
   localparam int unsigned TP  = calc_tp(M, N, VCW, A, SB, D),
   localparam int unsigned RP  = calc_rp(N, M, VCW, D)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           t_vld,
   input  logic [TP-1:0]  t_pld,
   output logic           t_gnt,
   output logic           req_vld,
   input  logic           req_gnt,
   output logic [VCW-1:0] req_vc,
   output logic           req_wr,
   output logic [A-1:0]   req_adr,
   output logic [SB-1:0]  req_sb,
   output logic [D/8-1:0] req_stb,
   output logic [D-1:0]   req_dat,
   input  logic           rsp_vld,
   output logic           rsp_gnt,
   input  logic [VCW-1:0] rsp_vc,
   input  logic           rsp_err,
   input  logic [D-1:0]   rsp_dat,
   output logic           r_vld,
   input  logic           r_gnt,
   output logic [RP-1:0]  r_pld,
   output logic           id_err,
   output logic           orphan_err,
   output logic [7:0]     drop_cnt
);

   localparam int unsigned SW     = D / 8;
   localparam int unsigned RW     = N + 1 + A + SB + SW + D;  // queued entry, VC implied
   localparam int unsigned OffDat = fld_off(FldDat, M, N, VCW, A, SB, D);
   localparam int unsigned OffStb = fld_off(FldStb, M, N, VCW, A, SB, D);
   localparam int unsigned OffSb  = fld_off(FldSb, M, N, VCW, A, SB, D);
   localparam int unsigned OffAdr = fld_off(FldAdr, M, N, VCW, A, SB, D);
   localparam int unsigned OffVc  = fld_off(FldVc, M, N, VCW, A, SB, D);
   localparam int unsigned OffWr  = fld_off(FldWr, M, N, VCW, A, SB, D);
   localparam int unsigned OffSrc = fld_off(FldSrc, M, N, VCW, A, SB, D);
   localparam int unsigned OffDst = fld_off(FldDst, M, N, VCW, A, SB, D);
   localparam logic [M-1:0]   OwnId  = M'(ID);
   localparam logic [VCW-1:0] LastVc = VCW'(VCN - 1);

   // ---------------------------------------------------------------- ingress
   logic [M-1:0]   pkt_dst;
   logic [VCW-1:0] pkt_vc;
   logic [RW-1:0]  pkt_body;
   logic           vc_room, vc_hit, id_ok, t_xfer;

   assign pkt_dst  = t_pld[OffDst +: M];
   assign pkt_vc   = t_pld[OffVc +: VCW];
   assign pkt_body = {t_pld[OffSrc +: N], t_pld[OffWr], t_pld[OffAdr +: A],
                      t_pld[OffSb +: SB], t_pld[OffStb +: SW], t_pld[OffDat +: D]};

   logic [VCN-1:0] req_push, req_pop, req_full, req_empty;
   logic [VCN-1:0] tag_push, tag_pop, tag_full, tag_empty;
   logic [RW-1:0]  req_rdata [VCN];
   logic [N-1:0]   tag_rdata [VCN];

   // A VC index beyond VCN has no queue: such a packet is accepted and dropped.
   always_comb begin
      vc_room = 1'b1;
      vc_hit  = 1'b0;
      for (int unsigned v = 0; v < VCN; v++) begin
         if (pkt_vc == VCW'(v)) begin
            vc_room = !req_full[v];
            vc_hit  = 1'b1;
         end
      end
   end

   assign t_gnt  = !rst && vc_room;
   assign t_xfer = t_vld && t_gnt;
   assign id_ok  = (pkt_dst == OwnId);

   always_ff @(posedge clk) begin
      if (rst) begin
         id_err   <= 1'b0;
         drop_cnt <= '0;
      end else if (t_xfer && !(id_ok && vc_hit)) begin
         if (!id_ok) id_err <= 1'b1;
         if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      end
   end

   // ---------------------------------------------------------------- arbiter
   logic [VCN-1:0] elig;
   logic [VCW-1:0] ptr_q, sel_q, rr_win, sel;
   logic           hold_q, rr_any, req_hs;
   logic [RW-1:0]  sel_entry;
   logic [N-1:0]   sel_src;
   int unsigned    k;

   assign elig = ~req_empty & ~tag_full;

   always_comb begin
      rr_win = ptr_q;
      rr_any = 1'b0;
      k      = 0;
      for (int unsigned i = 0; i < VCN; i++) begin
         k = 32'(ptr_q) + i;
         if (k >= VCN) k = k - VCN;
         if (!rr_any && elig[k]) begin
            rr_any = 1'b1;
            rr_win = VCW'(k);
         end
      end
   end

   // A stalled request keeps its VC: that VC stays eligible until it is granted
   // because its queue only pops and its tag FIFO only fills on a handshake.
   assign sel     = hold_q ? sel_q : rr_win;
   assign req_vld = !rst && (hold_q || rr_any);
   assign req_hs  = req_vld && req_gnt;
   assign req_vc  = sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= '0;
         sel_q  <= '0;
         hold_q <= 1'b0;
      end else begin
         hold_q <= req_vld && !req_gnt;
         sel_q  <= sel;
         if (req_hs) ptr_q <= (sel == LastVc) ? '0 : sel + 1'b1;
      end
   end

   always_comb begin
      sel_entry = '0;
      for (int unsigned v = 0; v < VCN; v++) begin
         if (sel == VCW'(v)) sel_entry = req_rdata[v];
      end
   end

   assign {sel_src, req_wr, req_adr, req_sb, req_stb, req_dat} = sel_entry;

   // --------------------------------------------------------------- response
   logic          rsp_hs, rsp_tag_ok;
   logic [N-1:0]  rsp_tag;
   logic          r_vld_q;
   logic [RP-1:0] r_pld_q;

   assign rsp_gnt = !rst && (!r_vld_q || r_gnt);
   assign rsp_hs  = rsp_vld && rsp_gnt;

   always_comb begin
      rsp_tag_ok = 1'b0;
      rsp_tag    = '0;
      for (int unsigned v = 0; v < VCN; v++) begin
         if (rsp_vc == VCW'(v)) begin
            rsp_tag_ok = !tag_empty[v];
            rsp_tag    = tag_rdata[v];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_q    <= 1'b0;
         r_pld_q    <= '0;
         orphan_err <= 1'b0;
      end else begin
         if (rsp_hs && rsp_tag_ok) begin
            r_vld_q <= 1'b1;
            r_pld_q <= {rsp_tag, OwnId, rsp_vc, rsp_err, rsp_dat};
         end else if (r_gnt) begin
            r_vld_q <= 1'b0;
         end
         if (rsp_hs && !rsp_tag_ok) orphan_err <= 1'b1;
      end
   end

   assign r_vld = r_vld_q;
   assign r_pld = r_pld_q;

   // ------------------------------------------------------------ per-VC FIFOs
   for (genvar v = 0; v < VCN; v++) begin : g_vc
      assign req_push[v] = t_xfer && id_ok && (pkt_vc == VCW'(v));
      assign req_pop[v]  = req_hs && (sel == VCW'(v));
      assign tag_push[v] = req_pop[v];
      assign tag_pop[v]  = rsp_hs && (rsp_vc == VCW'(v)) && !tag_empty[v];

      xt_sfifo #(
         .Width(RW),
         .Depth(BUF)
      ) u_req_fifo (
         .clk  (clk),
         .rst  (rst),
         .push (req_push[v]),
         .wdata(pkt_body),
         .pop  (req_pop[v]),
         .rdata(req_rdata[v]),
         .full (req_full[v]),
         .empty(req_empty[v])
      );

      xt_sfifo #(
         .Width(N),
         .Depth(OST)
      ) u_tag_fifo (
         .clk  (clk),
         .rst  (rst),
         .push (tag_push[v]),
         .wdata(sel_src),
         .pop  (tag_pop[v]),
         .rdata(tag_rdata[v]),
         .full (tag_full[v]),
         .empty(tag_empty[v])
      );
   end

endmodule

// File: tb/tb_xt_unit_mvc.sv
// Directed self-checking bench for xt_unit_mvc with default parameters.
module tb_xt_unit_mvc;
   import xt_unit_pkg::*;

   localparam int unsigned N   = 2;
   localparam int unsigned M   = 3;
   localparam int unsigned A   = 19;
   localparam int unsigned D   = 32;
   localparam int unsigned SB  = 4;
   localparam int unsigned VCN = 2;
   localparam int unsigned VCW = calc_vcw(VCN);
   localparam int unsigned TP  = calc_tp(M, N, VCW, A, SB, D);
   localparam int unsigned RP  = calc_rp(N, M, VCW, D);

   logic           clk = 1'b0;
   logic           rst;
   logic           t_vld;
   logic [TP-1:0]  t_pld;
   logic           t_gnt;
   logic           req_vld, req_gnt;
   logic [VCW-1:0] req_vc;
   logic           req_wr;
   logic [A-1:0]   req_adr;
   logic [SB-1:0]  req_sb;
   logic [D/8-1:0] req_stb;
   logic [D-1:0]   req_dat;
   logic           rsp_vld, rsp_gnt;
   logic [VCW-1:0] rsp_vc;
   logic           rsp_err;
   logic [D-1:0]   rsp_dat;
   logic           r_vld, r_gnt;
   logic [RP-1:0]  r_pld;
   logic           id_err, orphan_err;
   logic [7:0]     drop_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   int iss0   = 0;
   int iss1   = 0;

   always #5 clk = ~clk;

   xt_unit_mvc u_dut (
      .clk       (clk),
      .rst       (rst),
      .t_vld     (t_vld),
      .t_pld     (t_pld),
      .t_gnt     (t_gnt),
      .req_vld   (req_vld),
      .req_gnt   (req_gnt),
      .req_vc    (req_vc),
      .req_wr    (req_wr),
      .req_adr   (req_adr),
      .req_sb    (req_sb),
      .req_stb   (req_stb),
      .req_dat   (req_dat),
      .rsp_vld   (rsp_vld),
      .rsp_gnt   (rsp_gnt),
      .rsp_vc    (rsp_vc),
      .rsp_err   (rsp_err),
      .rsp_dat   (rsp_dat),
      .r_vld     (r_vld),
      .r_gnt     (r_gnt),
      .r_pld     (r_pld),
      .id_err    (id_err),
      .orphan_err(orphan_err),
      .drop_cnt  (drop_cnt)
   );

   // Inputs only change just after posedge, so negedge sees the handshake that
   // the following posedge will take.
   always @(negedge clk) begin
      if (req_vld && req_gnt) begin
         if (req_vc == 1'b0) iss0 <= iss0 + 1;
         else                iss1 <= iss1 + 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [TP-1:0] mk_pkt(input logic [M-1:0] dst, input logic [N-1:0] src,
                                           input logic wr, input logic [VCW-1:0] vc,
                                           input logic [A-1:0] adr, input logic [SB-1:0] sb,
                                           input logic [D/8-1:0] stb, input logic [D-1:0] dat);
      return {dst, src, wr, vc, adr, sb, stb, dat};
   endfunction

   logic [RP-1:0] exp_pld;
   logic [1:0]    src_b;
   logic          vc_b, err_b;
   int            b0, b1;

   initial begin
      rst = 1'b1; t_vld = 1'b0; t_pld = '0; req_gnt = 1'b0;
      rsp_vld = 1'b0; rsp_vc = '0; rsp_err = 1'b0; rsp_dat = '0; r_gnt = 1'b0;
      tick();
      tick();
      // Grants stay low while reset is held.
      t_vld = 1'b1; t_pld = mk_pkt(3'd0, 2'd0, 1'b0, 1'b0, '0, '0, '0, '0); rsp_vld = 1'b1;
      #1;
      check_eq("rst_t_gnt", t_gnt, 0);
      check_eq("rst_rsp_gnt", rsp_gnt, 0);
      t_vld = 1'b0; rsp_vld = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      check_eq("rst_req_vld", req_vld, 0);
      check_eq("rst_r_vld", r_vld, 0);
      check_eq("rst_id_err", id_err, 0);
      check_eq("rst_orphan", orphan_err, 0);
      check_eq("rst_drop", drop_cnt, 0);

      // Single write on VC1, response routed back to SRC 2.
      t_vld = 1'b1; req_gnt = 1'b1;
      t_pld = mk_pkt(3'd0, 2'd2, 1'b1, 1'b1, 19'h1234, 4'h3, 4'hf, 32'hdeadbeef);
      #1;
      check_eq("wr_t_gnt", t_gnt, 1);
      check_eq("wr_no_early_req", req_vld, 0);
      tick();
      t_vld = 1'b0;
      #1;
      check_eq("wr_req_vld", req_vld, 1);
      check_eq("wr_req_vc", req_vc, 1);
      check_eq("wr_req_wr", req_wr, 1);
      check_eq("wr_req_adr", req_adr, 64'h1234);
      check_eq("wr_req_sb", req_sb, 3);
      check_eq("wr_req_stb", req_stb, 4'hf);
      check_eq("wr_req_dat", req_dat, 64'hdeadbeef);
      tick();
      check_eq("wr_req_done", req_vld, 0);
      rsp_vld = 1'b1; rsp_vc = 1'b1; rsp_err = 1'b0; rsp_dat = 32'h5555;
      #1;
      check_eq("wr_rsp_gnt", rsp_gnt, 1);
      tick();
      // Keep a VC0 response offered while r_gnt is low: it must not be taken.
      rsp_vc = 1'b0; rsp_dat = 32'h9999;
      #1;
      exp_pld = {2'd2, 3'd0, 1'b1, 1'b0, 32'h5555};
      check_eq("wr_r_vld", r_vld, 1);
      check_eq("wr_r_pld", r_pld, exp_pld);

      // Backpressure on r_gnt.
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("bp_r_pld", r_pld, exp_pld);
         check_eq("bp_r_vld", r_vld, 1);
         check_eq("bp_rsp_gnt", rsp_gnt, 0);
      end
      check_eq("bp_orphan_clear", orphan_err, 0);
      // Releasing r_gnt lets the VC0 response in; VC0 has no tag so it is an orphan.
      r_gnt = 1'b1;
      tick();
      rsp_vld = 1'b0;
      #1;
      check_eq("orphan_err", orphan_err, 1);
      check_eq("orphan_no_r_vld", r_vld, 0);

      // Misrouted packets.
      t_vld = 1'b1; t_pld = mk_pkt(3'd5, 2'd1, 1'b0, 1'b0, '0, '0, '0, '0);
      #1;
      check_eq("mis_t_gnt", t_gnt, 1);
      tick();
      t_vld = 1'b0;
      #1;
      check_eq("mis_req_vld", req_vld, 0);
      check_eq("mis_id_err", id_err, 1);
      check_eq("mis_drop1", drop_cnt, 1);
      t_vld = 1'b1;
      repeat (299) tick();
      t_vld = 1'b0;
      #1;
      check_eq("mis_drop_sat", drop_cnt, 255);
      check_eq("mis_req_vld2", req_vld, 0);

      // Round-robin across VC0/VC1 with three requests each.
      req_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         t_vld = 1'b1;
         t_pld = mk_pkt(3'd0, 2'(i), 1'b0, 1'b0, 19'(32'h100 + i), '0, 4'hf, 32'(32'h100 + i));
         tick();
         t_pld = mk_pkt(3'd0, 2'(3 - i), 1'b1, 1'b1, 19'(32'h200 + i), '0, 4'hf, 32'(32'h200 + i));
         tick();
      end
      t_vld = 1'b0;
      #1;
      check_eq("rr_hold_vld", req_vld, 1);
      check_eq("rr_hold_vc", req_vc, 0);
      check_eq("rr_hold_adr", req_adr, 64'h100);
      req_gnt = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         check_eq("rr_vc", req_vc, 64'(k % 2));
         check_eq("rr_adr", req_adr, 64'(((k % 2) != 0 ? 32'h200 : 32'h100) + k / 2));
         tick();
      end
      check_eq("rr_drained", req_vld, 0);
      for (int k = 0; k < 6; k++) begin
         vc_b  = (k >= 3);
         err_b = (k == 4);
         src_b = vc_b ? 2'(3 - (k % 3)) : 2'(k % 3);
         rsp_vld = 1'b1; rsp_vc = vc_b; rsp_err = err_b; rsp_dat = 32'(32'h700 + k);
         tick();
         rsp_vld = 1'b0; rsp_err = 1'b0;
         #1;
         exp_pld = {src_b, 3'd0, vc_b, err_b, 32'(32'h700 + k)};
         check_eq("rr_rsp_pld", r_pld, exp_pld);
      end

      // Outstanding limit on VC0 while VC1 keeps flowing.
      b0 = iss0; b1 = iss1;
      for (int k = 0; k < 5; k++) begin
         t_vld = 1'b1;
         t_pld = mk_pkt(3'd0, 2'(k), 1'b0, 1'b0, 19'(32'h300 + k), '0, 4'hf, '0);
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         t_pld = mk_pkt(3'd0, 2'(k), 1'b0, 1'b1, 19'(32'h400 + k), '0, 4'hf, '0);
         tick();
      end
      t_vld = 1'b0;
      repeat (4) tick();
      check_eq("ost_vc0_issued", iss0 - b0, 4);
      check_eq("ost_vc1_issued", iss1 - b1, 2);
      check_eq("ost_stalled", req_vld, 0);
      rsp_vld = 1'b1; rsp_vc = 1'b0; rsp_dat = 32'h0abc;
      tick();
      rsp_vld = 1'b0;
      #1;
      exp_pld = {2'd0, 3'd0, 1'b0, 1'b0, 32'h0abc};
      check_eq("ost_rsp_pld", r_pld, exp_pld);
      tick();
      check_eq("ost_vc0_fifth", iss0 - b0, 5);

      // Reset with requests queued on VC1.
      req_gnt = 1'b0;
      for (int k = 0; k < 2; k++) begin
         t_vld = 1'b1;
         t_pld = mk_pkt(3'd0, 2'd3, 1'b0, 1'b1, 19'(32'h500 + k), '0, 4'hf, '0);
         tick();
      end
      t_pld = mk_pkt(3'd0, 2'd1, 1'b1, 1'b0, 19'h4444, 4'h5, 4'h3, 32'h12345678);
      #1;
      check_eq("mr_queued", req_vld, 1);
      rst = 1'b1;
      tick();
      check_eq("mr_req_vld", req_vld, 0);
      check_eq("mr_t_gnt", t_gnt, 0);
      check_eq("mr_drop", drop_cnt, 0);
      check_eq("mr_orphan", orphan_err, 0);
      rst = 1'b0; req_gnt = 1'b1;
      #1;
      check_eq("mr_t_gnt_back", t_gnt, 1);
      check_eq("mr_no_stale", req_vld, 0);
      tick();
      t_vld = 1'b0;
      #1;
      check_eq("mr_new_vld", req_vld, 1);
      check_eq("mr_new_vc", req_vc, 0);
      check_eq("mr_new_adr", req_adr, 64'h4444);
      check_eq("mr_new_dat", req_dat, 64'h12345678);
      tick();
      check_eq("mr_new_done", req_vld, 0);
      rsp_vld = 1'b1; rsp_vc = 1'b0; rsp_err = 1'b1; rsp_dat = 32'hcafe;
      tick();
      rsp_vc = 1'b1; rsp_err = 1'b0; rsp_dat = 32'h1;
      #1;
      exp_pld = {2'd1, 3'd0, 1'b0, 1'b1, 32'hcafe};
      check_eq("mr_rsp_pld", r_pld, exp_pld);
      check_eq("mr_rsp_vld", r_vld, 1);
      // The pre-reset VC1 request never issued, so this response is an orphan.
      tick();
      rsp_vld = 1'b0;
      #1;
      check_eq("mr_orphan_set", orphan_err, 1);
      check_eq("mr_orphan_no_r", r_vld, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/xt_unit_mvc.md
XT_UNIT_MVC -- requirements
Module: xt_unit_mvc

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- N, 2, source-ID width
- M, 3, target-ID width
- A, 19, address width
- D, 32, data width, multiple of 8
- SB, 4, request sideband width
- VCN, 2, virtual-channel count
- BUF, 4, per-VC request FIFO depth, power of 2
- OST, 4, per-VC outstanding-response limit, power of 2
- ID, 0, own target ID
REQ-002 SHALL derive the following:
- VCW = max(1, clog2(VCN))
- TP = M+N+1+VCW+A+SB+D/8+D
- RP = N+M+VCW+1+D
REQ-003 SHALL have ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock
- rst, in, 1, synchronous active-high reset
- t_vld, in, 1, switch packet valid
- t_pld, in, TP, packet {DST_ID,SRC_ID,WR,VC,ADR,SB,STB,DAT}, MSB first
- t_gnt, out, 1, packet accepted
- req_vld, out, 1, target request valid
- req_gnt, in, 1, target request grant
- req_vc, out, VCW, request VC
- req_wr, out, 1, write
- req_adr, out, A, address
- req_sb, out, SB, sideband
- req_stb, out, D/8, byte strobes
- req_dat, out, D, write data
- rsp_vld, in, 1, target response valid
- rsp_gnt, out, 1, response accepted
- rsp_vc, in, VCW, response VC
- rsp_err, in, 1, target error
- rsp_dat, in, D, read data, or don't-care for writes
- r_vld, out, 1, response packet valid
- r_gnt, in, 1, response packet grant
- r_pld, out, RP, response packet {DST_ID=tag,SRC_ID=ID,VC,ERR,DAT}
- id_err, out, 1, sticky misrouted-packet flag
- orphan_err, out, 1, sticky orphan-response flag
- drop_cnt, out, 8, count of dropped packets, saturating

Function
REQ-004 SHALL drive t_gnt = !rst && request FIFO[t_pld.VC] not full. A transfer occurs on t_vld&&t_gnt. There is no full-FIFO bypass.
REQ-005 SHALL consume a transferred packet with DST_ID != ID[M-1:0] without forwarding it. Such a packet sets id_err and increments drop_cnt, which holds at 255.
REQ-006 SHALL push valid packets into the request FIFO of their VC. A packet accepted in cycle T is presented on req_* no earlier than T+1.
REQ-007 SHALL treat a VC as eligible when its request FIFO is non-empty and its tag FIFO holds fewer than OST entries.
REQ-008 SHALL select among eligible VCs round-robin. The pointer moves to winner+1 (mod VCN) only on a req_vld&&req_gnt handshake.
REQ-009 SHALL hold req_* and the selected VC stable while req_vld && !req_gnt. A newly eligible VC SHALL NOT preempt the held selection.
REQ-010 SHALL, on a request handshake, pop that VC's request FIFO and push its SRC_ID into the VC's tag FIFO in the same cycle. Back-to-back issue, one request per cycle, SHALL be supported.
REQ-011 SHALL keep responses in order within each VC. Responses on different VCs are independent, and a full tag FIFO stalls only its own VC.
REQ-012 SHALL drive rsp_gnt = !rst && (!r_vld || r_gnt). On a response handshake it SHALL:
- pop tag FIFO[rsp_vc];
- register r_pld = {tag, ID[M-1:0], rsp_vc, rsp_err, rsp_dat};
- assert r_vld in the next cycle (latency 1).
REQ-013 SHALL hold r_vld and r_pld stable until r_gnt. r_gnt together with a new rsp handshake in the same cycle SHALL reload r_pld without a bubble.
REQ-014 SHALL consume a response whose tag FIFO is empty without producing r_vld, and SHALL set orphan_err.
REQ-015 SHALL support a tag push and a tag pop on the same VC in the same cycle, leaving the occupancy unchanged.
REQ-016 SHALL support request FIFO push and pop in the same cycle. Pointers SHALL wrap modulo depth, and full/empty SHALL be distinguished with an extra pointer bit.

Reset
REQ-017 SHALL, on rst sampled high at a clk edge, do the following:
- empty all FIFOs;
- set the round-robin pointer to VC0;
- clear req_vld, r_vld, id_err, orphan_err and drop_cnt;
- hold t_gnt=0 and rsp_gnt=0 while rst is high.
REQ-018 SHALL discard all in-flight contents on a mid-operation reset. Responses returning after reset are orphans (REQ-014).

Structure
REQ-019 SHALL place VCW and the payload field offset and width helper functions in package xt_unit_pkg. Both this module and the bench SHALL use the package.
REQ-020 SHALL use one sub-module, xt_sfifo (width and depth parametrised, synchronous, registered full/empty). It is instantiated VCN times with depth BUF for requests and VCN times with depth OST for tags.

Verification
REQ-021 SHALL cover: one write, ID=0, DST=0, SRC=2, VC1, ADR=0x1234, DAT=0xDEADBEEF, with req_gnt held high -> req_* matches one cycle later; rsp VC1 -> r_pld DST=2, ERR=0.
REQ-022 SHALL cover: DST=5 with ID=0 -> t_gnt=1, no req_vld, id_err=1, drop_cnt=1; 300 such packets -> drop_cnt=255.
REQ-023 SHALL cover: VC0 and VC1 each with 3 pending requests and req_gnt always 1 -> issue order VC0,VC1,VC0,VC1,VC0,VC1.
REQ-024 SHALL cover: OST=4, five VC0 requests, no responses -> exactly 4 issued while VC1 traffic continues; one VC0 response -> the 5th request issues.
REQ-025 SHALL cover: r_gnt=0 for 10 cycles -> r_pld stable, rsp_gnt=0 after the first capture; an rsp with an empty tag FIFO -> orphan_err=1 and no r_vld.
REQ-026 SHALL cover: rst asserted with 2 requests queued -> the next cycle has req_vld=0 and t_gnt=0; the first packet after reset issues normally.
